// File: rtl/decode_packet.sv
// Receive-side packet decoder: checks flit sequence numbers, reassembles NUMBER_PACKET flits
// into a payload plus destination address, and presents the result with a valid/ready handshake.
module decode_packet #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = 1034,
    parameter int NUMBER_PACKET     = 19,
    parameter int AURORA_DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_valid_i,
    output logic                         fifo_ready_o,
    input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
    output logic                         decode_valid_o,
    input  logic                         decode_ready_i,
    output logic [DATA_WIDTH-1:0]        data_decode_o,
    output logic [ADDR_WIDTH-1:0]        router_dst_addr_o,
    output logic [1:0]                   src_router_o,
    output logic [1:0]                   ttl_o,
    output logic                         decode_done,
    output logic                         decode_err
);

    localparam int HDR_W   = 9;
    localparam int SLICE_W = AURORA_DATA_WIDTH - HDR_W;
    localparam int LAST_W  = DATA_DFX_WIDTH - (NUMBER_PACKET - 1) * SLICE_W;
    localparam int CNT_W   = 5;
    localparam logic [CNT_W-1:0] LAST_PKT = CNT_W'(NUMBER_PACKET - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StOutput} state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          exp_cnt_q;
    logic [DATA_DFX_WIDTH-1:0] dfx_q;
    logic [1:0]                src_q;
    logic [1:0]                ttl_q;
    logic                      valid_q;
    logic                      done_q;
    logic                      err_q;

    logic             accept;
    logic [CNT_W-1:0] pkt_num;
    logic [1:0]       flit_src;
    logic [1:0]       flit_ttl;
    logic             tail_pad_err;

    assign fifo_ready_o = !rst && (state_q != StOutput);
    assign accept       = fifo_valid_i && fifo_ready_o;
    assign pkt_num      = data_recv[6:2];
    assign flit_src     = data_recv[1:0];
    assign flit_ttl     = data_recv[8:7];
    // Last flit only carries LAST_W payload bits; anything above must be zero padding.
    assign tail_pad_err = |data_recv[AURORA_DATA_WIDTH-1:HDR_W+LAST_W];

    function automatic logic [DATA_DFX_WIDTH-1:0] put_slice(
        input logic [DATA_DFX_WIDTH-1:0]    cur,
        input logic [CNT_W-1:0]             slot,
        input logic [AURORA_DATA_WIDTH-1:0] flit
    );
        logic [DATA_DFX_WIDTH-1:0] r;
        r = cur;
        for (int k = 0; k < NUMBER_PACKET - 1; k++) begin
            if (slot == CNT_W'(k)) begin
                r[k*SLICE_W +: SLICE_W] = flit[AURORA_DATA_WIDTH-1:HDR_W];
            end
        end
        if (slot == LAST_PKT) begin
            r[DATA_DFX_WIDTH-1 -: LAST_W] = flit[HDR_W +: LAST_W];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            exp_cnt_q <= '0;
            dfx_q     <= '0;
            src_q     <= '0;
            ttl_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (pkt_num == '0) begin
                            dfx_q     <= put_slice(dfx_q, '0, data_recv);
                            src_q     <= flit_src;
                            ttl_q     <= flit_ttl;
                            exp_cnt_q <= CNT_W'(1);
                            state_q   <= StCollect;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    if (accept) begin
                        if (pkt_num == exp_cnt_q && flit_src == src_q) begin
                            dfx_q <= put_slice(dfx_q, exp_cnt_q, data_recv);
                            if (exp_cnt_q == LAST_PKT) begin
                                state_q   <= StOutput;
                                exp_cnt_q <= '0;
                                valid_q   <= 1'b1;
                                err_q     <= tail_pad_err;
                            end else begin
                                exp_cnt_q <= exp_cnt_q + 1'b1;
                            end
                        end else begin
                            err_q <= 1'b1;
                            // A stray flit 0 is treated as the start of a fresh packet.
                            if (pkt_num == '0) begin
                                dfx_q     <= put_slice(dfx_q, '0, data_recv);
                                src_q     <= flit_src;
                                ttl_q     <= flit_ttl;
                                exp_cnt_q <= CNT_W'(1);
                            end else begin
                                state_q   <= StIdle;
                                exp_cnt_q <= '0;
                            end
                        end
                    end
                end
                StOutput: begin
                    if (decode_ready_i) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign decode_valid_o    = valid_q;
    assign data_decode_o     = dfx_q[DATA_DFX_WIDTH-1:ADDR_WIDTH];
    assign router_dst_addr_o = dfx_q[ADDR_WIDTH-1:0];
    assign src_router_o      = src_q;
    assign ttl_o             = ttl_q;
    assign decode_done       = done_q;
    assign decode_err        = err_q;

endmodule

// File: tb/tb_decode_packet.sv
// Bench for decode_packet: flits built by an encoder model, expected packets queued in a
// scoreboard and popped by a monitor on each output handshake.
module tb_decode_packet;

    localparam int DW = 1034;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_valid_i = 1'b0;
    logic          fifo_ready_o;
    logic [63:0]   data_recv = '0;
    logic          decode_valid_o;
    logic          decode_ready_i = 1'b1;
    logic [1023:0] data_decode_o;
    logic [9:0]    router_dst_addr_o;
    logic [1:0]    src_router_o;
    logic [1:0]    ttl_o;
    logic          decode_done;
    logic          decode_err;

    decode_packet dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_valid_i     (fifo_valid_i),
        .fifo_ready_o     (fifo_ready_o),
        .data_recv        (data_recv),
        .decode_valid_o   (decode_valid_o),
        .decode_ready_i   (decode_ready_i),
        .data_decode_o    (data_decode_o),
        .router_dst_addr_o(router_dst_addr_o),
        .src_router_o     (src_router_o),
        .ttl_o            (ttl_o),
        .decode_done      (decode_done),
        .decode_err       (decode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dfx;
        logic [1:0]    src;
        logic [1:0]    ttl;
    } pkt_t;

    pkt_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   err_seen = 0;
    logic hs_prev  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic check_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: %0d bits differ, got low %h want low %h",
                      name, $countones(act ^ exp), act[127:0], exp[127:0]);
    endtask

    // Encoder model: flit k of a packet.
    function automatic logic [63:0] enc(input logic [DW-1:0] dfx, input logic [1:0] src,
                                        input logic [1:0] ttl, input int k);
        logic [8:0] hdr;
        hdr = {ttl, 5'(k), src};
        if (k < 18) return {dfx[k*55 +: 55], hdr};
        return {11'b0, dfx[1033:990], hdr};
    endfunction

    function automatic logic [DW-1:0] rand_dfx();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 33; i++) r = (r << 32) | DW'($urandom());
        return r;
    endfunction

    // Monitor: pops the scoreboard on each handshake and checks the done pulse after it.
    always @(negedge clk) begin
        pkt_t p;
        logic hs;
        if (decode_err === 1'b1) err_seen++;
        if (hs_prev || decode_done) check("done_pulse", 64'(decode_done), 64'(hs_prev));
        hs = decode_valid_o && decode_ready_i && !rst;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("unexpected_packet", 64'(1), 64'(0));
            end else begin
                p = exp_q.pop_front();
                check_wide("payload", {data_decode_o, router_dst_addr_o}, p.dfx);
                check("dst_addr", 64'(router_dst_addr_o), 64'(p.dfx[9:0]));
                check("src_router", 64'(src_router_o), 64'(p.src));
                check("ttl", 64'(ttl_o), 64'(p.ttl));
            end
        end
        hs_prev = hs;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fifo_valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_flit(input logic [63:0] f);
        logic acc;
        int   guard;
        fifo_valid_i = 1'b1;
        data_recv    = f;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = fifo_ready_o;
            tick();
            guard++;
        end
        if (!acc) check("flit_accept_timeout", 64'(0), 64'(1));
        fifo_valid_i = 1'b0;
    endtask

    task automatic send_range(input logic [DW-1:0] dfx, input logic [1:0] src,
                              input logic [1:0] ttl, input int first, input int last,
                              input int gap_pct);
        for (int k = first; k <= last; k++) begin
            while (int'($urandom_range(99)) < gap_pct) idle(1);
            send_flit(enc(dfx, src, ttl, k));
        end
    endtask

    task automatic send_packet(input logic [DW-1:0] dfx, input logic [1:0] src,
                               input logic [1:0] ttl, input int gap_pct);
        pkt_t p;
        p.dfx = dfx;
        p.src = src;
        p.ttl = ttl;
        exp_q.push_back(p);
        send_range(dfx, src, ttl, 0, 18, gap_pct);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        repeat (2) tick();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] a;
        logic [7:0]    b;
        int            e0;
        pkt_t          p;

        // Reset state
        repeat (2) tick();
        check("rst_fifo_ready", 64'(fifo_ready_o), 64'(0));
        check("rst_valid", 64'(decode_valid_o), 64'(0));
        check_wide("rst_data", {data_decode_o, router_dst_addr_o}, '0);
        check("rst_src_ttl", 64'({src_router_o, ttl_o}), 64'(0));
        check("rst_done_err", 64'({decode_done, decode_err}), 64'(0));
        rst = 1'b0;
        tick();
        check("idle_fifo_ready", 64'(fifo_ready_o), 64'(1));

        // 1: incrementing-byte payload, latency of valid
        d = '0;
        for (int i = 0; i < 128; i++) begin
            b = 8'(i);
            d[10 + i*8 +: 8] = b;
        end
        d[9:0] = 10'h155;
        p.dfx = d; p.src = 2'd2; p.ttl = 2'd3;
        exp_q.push_back(p);
        send_range(d, 2'd2, 2'd3, 0, 17, 0);
        check("t1_valid_before_last", 64'(decode_valid_o), 64'(0));
        send_flit(enc(d, 2'd2, 2'd3, 18));
        check("t1_valid_after_last", 64'(decode_valid_o), 64'(1));
        drain();

        // 2: output backpressure with FIFO still offering a flit
        decode_ready_i = 1'b0;
        e0 = err_seen;
        d = rand_dfx();
        send_packet(d, 2'd1, 2'd2, 0);
        fifo_valid_i = 1'b1;
        data_recv    = {55'h0, 2'd0, 5'd5, 2'd1};
        for (int c = 0; c < 10; c++) begin
            check("t2_fifo_ready_low", 64'(fifo_ready_o), 64'(0));
            check("t2_valid_held", 64'(decode_valid_o), 64'(1));
            check_wide("t2_data_held", {data_decode_o, router_dst_addr_o}, d);
            tick();
        end
        fifo_valid_i   = 1'b0;
        decode_ready_i = 1'b1;
        drain();
        check("t2_no_flit_consumed", 64'(err_seen - e0), 64'(0));

        // 3: sequence gap aborts to idle
        e0 = err_seen;
        a = rand_dfx();
        send_range(a, 2'd0, 2'd1, 0, 5, 0);
        send_flit(enc(a, 2'd0, 2'd1, 7));
        idle(3);
        check("t3_err_pulses", 64'(err_seen - e0), 64'(1));
        send_packet(rand_dfx(), 2'd3, 2'd0, 0);
        drain();

        // 4: restart on a fresh flit 0 mid-packet
        e0 = err_seen;
        a = rand_dfx();
        d = rand_dfx();
        send_range(a, 2'd2, 2'd1, 0, 9, 0);
        send_packet(d, 2'd1, 2'd2, 0);
        drain();
        check("t4_err_pulses", 64'(err_seen - e0), 64'(1));

        // 5: reset mid-packet
        a = rand_dfx();
        send_range(a, 2'd3, 2'd3, 0, 12, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_fifo_ready_in_rst", 64'(fifo_ready_o), 64'(0));
        tick();
        check("t5_valid", 64'(decode_valid_o), 64'(0));
        check_wide("t5_data", {data_decode_o, router_dst_addr_o}, '0);
        check("t5_src_ttl", 64'({src_router_o, ttl_o}), 64'(0));
        rst = 1'b0;
        tick();
        send_packet(rand_dfx(), 2'd0, 2'd2, 0);
        drain();

        // 7: nonzero padding in the last flit still delivers the packet
        e0 = err_seen;
        d = rand_dfx();
        p.dfx = d; p.src = 2'd1; p.ttl = 2'd1;
        exp_q.push_back(p);
        send_range(d, 2'd1, 2'd1, 0, 17, 0);
        send_flit(enc(d, 2'd1, 2'd1, 18) | {11'($urandom_range(2047, 1)), 53'h0});
        drain();
        check("t7_pad_err", 64'(err_seen - e0), 64'(1));

        // 6: random gaps over many packets
        e0 = err_seen;
        for (int n = 0; n < 50; n++) begin
            send_packet(rand_dfx(), 2'($urandom_range(3)), 2'($urandom_range(3)), 30);
        end
        drain();
        check("t6_no_err", 64'(err_seen - e0), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
